// File: rtl/obi_resp_pkg.sv
// Shared types and helpers for the OBI data-side responder.
package obi_resp_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Word index of a byte address; the caller truncates to the memory depth.
  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/obi_data_responder_be_sram.sv
// Single-port word memory with per-byte write enables and a registered read.
module be_sram
  import obi_resp_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Byte-masked write; the read port samples the array every cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/obi_data_responder.sv
// Configurable-latency memory-side responder for the core's data port.
// state | meaning
// IDLE  | no request pending; zero-wait requests are granted here directly
// WAIT  | counting grant wait states up to the latched limit
module obi_data_responder
  import obi_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 data_req_i,
  input  logic [31:0]          data_addr_i,
  input  logic                 data_we_i,
  input  logic [BE_W-1:0]      data_be_i,
  input  logic [WORD_W-1:0]    data_wdata_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  output logic [WORD_W-1:0]    data_rdata_o,
  input  logic [3:0]           wait_cycles_i,
  output logic                 addr_err_o,
  output logic                 protocol_err_o,
  output logic [CNT_WIDTH-1:0] txn_count_o
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [3:0]           limit_q, limit_d;
  logic                 gnt_ok;
  logic                 perr_set;
  logic                 rvalid_q;
  logic                 rd_ok_q;
  logic                 aerr_q, perr_q;
  logic [CNT_WIDTH-1:0] txn_q;

  logic [29:0]           widx_full;
  logic [ADDR_WIDTH-3:0] widx;
  logic                  in_range;
  logic [WORD_W-1:0]     sram_rdata;

  // The word index carries the upper address bits, so range check uses it too.
  assign widx_full = word_index(data_addr_i);
  assign widx      = widx_full[ADDR_WIDTH-3:0];
  assign in_range  = ((widx_full >> (ADDR_WIDTH - 2)) == '0);

  // State register with wait counter and latched limit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

  // Next-state: limit is latched once so later wait_cycles_i changes are ignored.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    limit_d  = limit_q;
    perr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_req_i && wait_cycles_i != 4'd0) begin
          limit_d = wait_cycles_i;
          cnt_d   = 4'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!data_req_i) begin
          perr_set = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else if (cnt_q == limit_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant output; suppressed while reset is held.
  always_comb begin
    gnt_ok = 1'b0;
    unique case (state_q)
      IDLE:    gnt_ok = data_req_i && (wait_cycles_i == 4'd0);
      WAIT:    gnt_ok = data_req_i && (cnt_q == limit_q);
      default: gnt_ok = 1'b0;
    endcase
    data_gnt_o = gnt_ok && !rst_i;
  end

  // Response pipeline, sticky flags and granted-transaction counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rd_ok_q  <= 1'b0;
      aerr_q   <= 1'b0;
      perr_q   <= 1'b0;
      txn_q    <= '0;
    end else begin
      rvalid_q <= data_gnt_o;
      rd_ok_q  <= data_gnt_o && !data_we_i && in_range;
      if (data_gnt_o && !in_range) aerr_q <= 1'b1;
      if (perr_set) perr_q <= 1'b1;
      if (data_gnt_o) txn_q <= txn_q + CNT_WIDTH'(1);
    end
  end

  be_sram #(.DEPTH(DEPTH)) u_sram (
    .clk_i   (clk_i),
    .we_i    (data_gnt_o && data_we_i && in_range),
    .be_i    (data_be_i),
    .addr_i  (widx),
    .wdata_i (data_wdata_i),
    .rdata_o (sram_rdata)
  );

  // Write and out-of-range responses return zero data.
  assign data_rvalid_o  = rvalid_q;
  assign data_rdata_o   = rd_ok_q ? sram_rdata : '0;
  assign addr_err_o     = aerr_q;
  assign protocol_err_o = perr_q;
  assign txn_count_o    = txn_q;

endmodule

// File: tb/tb_obi_data_responder.sv
// Directed bench for obi_data_responder.
module tb_obi_data_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic [3:0]  wait_cycles_i;
  logic        addr_err_o;
  logic        protocol_err_o;
  logic [15:0] txn_count_o;

  int nerr = 0;
  int nchk = 0;

  always #5 clk_i = ~clk_i;

  obi_data_responder #(.ADDR_WIDTH(12), .CNT_WIDTH(16)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .data_req_i     (data_req_i),
    .data_addr_i    (data_addr_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .wait_cycles_i  (wait_cycles_i),
    .addr_err_o     (addr_err_o),
    .protocol_err_o (protocol_err_o),
    .txn_count_o    (txn_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [3:0] wc);
    data_req_i    = 1'b1;
    data_we_i     = we;
    data_addr_i   = addr;
    data_be_i     = be;
    data_wdata_i  = wdata;
    wait_cycles_i = wc;
    #1;
  endtask

  task automatic idle();
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0;
    data_be_i = '0; data_wdata_i = '0; wait_cycles_i = '0;
    tick();
    drive(1'b0, 32'h10, 4'hF, 32'h0, 4'd0);
    chk("gnt_in_reset", data_gnt_o, 1'b0);
    idle();
    tick();
    chk("rst_rvalid", data_rvalid_o, 1'b0);
    chk("rst_rdata", data_rdata_o, 32'h0);
    chk("rst_aerr", addr_err_o, 1'b0);
    chk("rst_perr", protocol_err_o, 1'b0);
    chk("rst_txn", txn_count_o, 32'd0);
    rst_i = 1'b0;
    tick();

    // Zero-wait write then read to same word
    drive(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 4'd0);
    chk("t1_wr_gnt", data_gnt_o, 1'b1);
    chk("t1_rvalid_pre", data_rvalid_o, 1'b0);
    tick();
    chk("t1_wr_rvalid", data_rvalid_o, 1'b1);
    chk("t1_wr_rdata", data_rdata_o, 32'h0);
    drive(1'b0, 32'h10, 4'hF, 32'h0, 4'd0);
    chk("t1_rd_gnt", data_gnt_o, 1'b1);
    tick();
    idle();
    chk("t1_rd_rvalid", data_rvalid_o, 1'b1);
    chk("t1_rd_rdata", data_rdata_o, 32'hDEADBEEF);
    chk("t1_txn", txn_count_o, 32'd2);
    tick();
    chk("t1_rvalid_drop", data_rvalid_o, 1'b0);

    // Partial byte-enable write
    drive(1'b1, 32'h12, 4'b0101, 32'h11223344, 4'd0);
    chk("t2_wr_gnt", data_gnt_o, 1'b1);
    tick();
    idle();
    tick();
    drive(1'b0, 32'h10, 4'h0, 32'h0, 4'd0);
    tick();
    idle();
    chk("t2_rdata", data_rdata_o, 32'hDE22BE44);

    // Three wait states, wait_cycles_i change ignored mid-wait
    drive(1'b0, 32'h10, 4'h0, 32'h0, 4'd3);
    chk("t3_gnt_c0", data_gnt_o, 1'b0);
    tick();
    wait_cycles_i = 4'd0; #1;
    chk("t3_gnt_c1", data_gnt_o, 1'b0);
    tick();
    chk("t3_gnt_c2", data_gnt_o, 1'b0);
    tick();
    chk("t3_gnt_c3", data_gnt_o, 1'b1);
    chk("t3_rvalid_c3", data_rvalid_o, 1'b0);
    tick();
    idle();
    chk("t3_rvalid_c4", data_rvalid_o, 1'b1);
    chk("t3_rdata_c4", data_rdata_o, 32'hDE22BE44);
    chk("t3_txn", txn_count_o, 32'd5);

    // Out-of-range read and write
    drive(1'b0, 32'h0001_0000, 4'h0, 32'h0, 4'd0);
    chk("t4_rd_gnt", data_gnt_o, 1'b1);
    tick();
    idle();
    chk("t4_rvalid", data_rvalid_o, 1'b1);
    chk("t4_rdata", data_rdata_o, 32'h0);
    chk("t4_aerr", addr_err_o, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    chk("t4_aerr_sticky", addr_err_o, 1'b1);
    drive(1'b1, 32'h0001_0010, 4'hF, 32'hCAFEF00D, 4'd0);
    chk("t4_wr_gnt", data_gnt_o, 1'b1);
    tick();
    drive(1'b0, 32'h10, 4'h0, 32'h0, 4'd0);
    tick();
    idle();
    chk("t4_mem_intact", data_rdata_o, 32'hDE22BE44);
    chk("t4_txn", txn_count_o, 32'd8);

    // Request withdrawn during wait
    drive(1'b0, 32'h10, 4'h0, 32'h0, 4'd3);
    tick();
    chk("t5_gnt_c1", data_gnt_o, 1'b0);
    chk("t5_perr_pre", protocol_err_o, 1'b0);
    tick();
    idle();
    chk("t5_gnt_c2", data_gnt_o, 1'b0);
    tick();
    chk("t5_perr", protocol_err_o, 1'b1);
    chk("t5_rvalid", data_rvalid_o, 1'b0);
    drive(1'b0, 32'h10, 4'h0, 32'h0, 4'd0);
    chk("t5_next_gnt", data_gnt_o, 1'b1);
    tick();
    idle();
    chk("t5_next_rvalid", data_rvalid_o, 1'b1);
    chk("t5_txn", txn_count_o, 32'd9);

    // Reset during WAIT
    drive(1'b0, 32'h10, 4'h0, 32'h0, 4'd3);
    tick();
    tick();
    rst_i = 1'b1; #1;
    chk("t6_gnt_rst_wait", data_gnt_o, 1'b0);
    tick();
    chk("t6_gnt_rst_held", data_gnt_o, 1'b0);
    chk("t6_txn", txn_count_o, 32'd0);
    chk("t6_aerr", addr_err_o, 1'b0);
    chk("t6_perr", protocol_err_o, 1'b0);
    rst_i = 1'b0;
    idle();
    tick();
    chk("t6_perr_after", protocol_err_o, 1'b0);
    chk("t6_rvalid_after", data_rvalid_o, 1'b0);

    // Reset in a would-be grant cycle, then a pending rvalid cut by reset
    drive(1'b0, 32'h10, 4'h0, 32'h0, 4'd0);
    rst_i = 1'b1; #1;
    chk("t6_gnt_rst_grant", data_gnt_o, 1'b0);
    tick();
    chk("t6_rvalid_rst", data_rvalid_o, 1'b0);
    chk("t6_txn_rst", txn_count_o, 32'd0);
    rst_i = 1'b0; #1;
    chk("t6_gnt_post_rst", data_gnt_o, 1'b1);
    tick();
    rst_i = 1'b1;
    idle();
    tick();
    chk("t6_rvalid_dropped", data_rvalid_o, 1'b0);
    chk("t6_txn_cleared", txn_count_o, 32'd0);
    rst_i = 1'b0;
    drive(1'b0, 32'h10, 4'h0, 32'h0, 4'd0);
    tick();
    idle();
    chk("t6_mem_kept", data_rdata_o, 32'hDE22BE44);
    chk("t6_txn_one", txn_count_o, 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
